// File: rtl/soc_bus_pkg.sv
`default_nettype none
// soc_bus_pkg: FSM states, error codes and error-window layout shared by the bus fabric.
package soc_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_RESP   = 2'b10
  } state_t;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_UNMAPPED = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

  // The error window spans two words; low three address bits select the register.
  localparam logic [31:0] ERR_WIN_MASK   = 32'hFFFF_FFF8;
  localparam logic [2:0]  ERR_OFF_ADDR   = 3'd0;
  localparam logic [2:0]  ERR_OFF_STATUS = 3'd4;

  function automatic logic [31:0] err_status_word(input logic [1:0] code, input logic [7:0] count);
    return {code, 22'b0, count};
  endfunction

endpackage
`default_nettype wire

// File: rtl/soc_bus_decode.sv
`default_nettype none
// soc_bus_decode: combinational address decoder; error window first, then lowest matching slave.
module soc_bus_decode
  import soc_bus_pkg::*;
#(
  parameter int                    N_SLAVES   = 4,
  parameter logic [32*N_SLAVES-1:0] SLAVE_BASE = {32'h0300_0000, 32'h0200_0000, 32'h0100_0000, 32'h0000_0000},
  parameter logic [32*N_SLAVES-1:0] SLAVE_MASK = {N_SLAVES{32'hFF00_0000}},
  parameter logic [31:0]           ERR_BASE   = 32'h02FF_0000
) (
  input  logic [31:0]         addr,
  output logic                err_hit,
  output logic [N_SLAVES-1:0] sel,
  output logic                miss
);

  logic [N_SLAVES-1:0] match;
  logic                found;

  for (genvar gi = 0; gi < N_SLAVES; gi++) begin : g_match
    assign match[gi] = ((addr & SLAVE_MASK[32*gi +: 32]) == SLAVE_BASE[32*gi +: 32]);
  end

  assign err_hit = ((addr & ERR_WIN_MASK) == ERR_BASE);

  always_comb begin
    sel   = '0;
    found = 1'b0;
    if (!err_hit) begin
      for (int i = 0; i < N_SLAVES; i++) begin
        if (match[i] && !found) begin
          sel[i] = 1'b1;
          found  = 1'b1;
        end
      end
    end
  end

  assign miss = !err_hit && !found;

endmodule
`default_nettype wire

// File: rtl/soc_bus_fabric.sv
`default_nettype none
// soc_bus_fabric: picorv32 native-bus interconnect to N slaves with unmapped/timeout
// error responses and a two-word error-status register window.
module soc_bus_fabric
  import soc_bus_pkg::*;
#(
  parameter int                    N_SLAVES       = 4,
  parameter logic [32*N_SLAVES-1:0] SLAVE_BASE     = {32'h0300_0000, 32'h0200_0000, 32'h0100_0000, 32'h0000_0000},
  parameter logic [32*N_SLAVES-1:0] SLAVE_MASK     = {N_SLAVES{32'hFF00_0000}},
  parameter logic [31:0]           ERR_BASE       = 32'h02FF_0000,
  parameter int                    TIMEOUT_CYCLES = 255,
  parameter logic [31:0]           ERR_RDATA      = 32'hDEAD_BEEF
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     m_valid,
  input  logic [31:0]              m_addr,
  input  logic [31:0]              m_wdata,
  input  logic [3:0]               m_wstrb,
  output logic                     m_ready,
  output logic [31:0]              m_rdata,
  output logic [N_SLAVES-1:0]      s_valid,
  output logic [31:0]              s_addr,
  output logic [31:0]              s_wdata,
  output logic [3:0]               s_wstrb,
  input  logic [N_SLAVES-1:0]      s_ready,
  input  logic [32*N_SLAVES-1:0]   s_rdata,
  output logic                     err_irq
);

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t              state, state_nxt;
  logic                err_hit, miss;
  logic [N_SLAVES-1:0] sel;
  logic [15:0]         to_cnt;
  logic [31:0]         err_addr;
  logic [1:0]          err_code;
  logic [7:0]          err_count;
  logic                launch, win_acc, unmapped, resp_ok, resp_to;
  logic                err_set, win_clr, slave_ready;
  logic [31:0]         sel_rdata, win_rdata;

  soc_bus_decode #(
    .N_SLAVES   (N_SLAVES),
    .SLAVE_BASE (SLAVE_BASE),
    .SLAVE_MASK (SLAVE_MASK),
    .ERR_BASE   (ERR_BASE)
  ) u_decode (
    .addr    (m_addr),
    .err_hit (err_hit),
    .sel     (sel),
    .miss    (miss)
  );

  // s_valid holds the one-hot select for the whole access, so it doubles as the response mux control.
  always_comb begin
    slave_ready = |(s_ready & s_valid);
    sel_rdata   = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (s_valid[i]) sel_rdata = sel_rdata | s_rdata[32*i +: 32];
    end
  end

  always_comb begin
    case (m_addr[2:0])
      ERR_OFF_ADDR:   win_rdata = err_addr;
      ERR_OFF_STATUS: win_rdata = err_status_word(err_code, err_count);
      default:        win_rdata = '0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    win_acc   = 1'b0;
    unmapped  = 1'b0;
    resp_ok   = 1'b0;
    resp_to   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (m_valid) begin
          if (err_hit) begin
            win_acc   = 1'b1;
            state_nxt = ST_RESP;
          end else if (miss) begin
            unmapped  = 1'b1;
            state_nxt = ST_RESP;
          end else begin
            launch    = 1'b1;
            state_nxt = ST_ACCESS;
          end
        end
      end
      ST_ACCESS: begin
        // A ready arriving on the last allowed cycle beats the timeout.
        if (slave_ready) begin
          resp_ok   = 1'b1;
          state_nxt = ST_RESP;
        end else if (to_cnt == TO_LAST) begin
          resp_to   = 1'b1;
          state_nxt = ST_RESP;
        end
      end
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign err_set = unmapped || resp_to;
  assign win_clr = win_acc && (m_addr[2:0] == ERR_OFF_STATUS) && (m_wstrb != 4'h0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_ready   <= 1'b0;
      m_rdata   <= '0;
      s_valid   <= '0;
      s_addr    <= '0;
      s_wdata   <= '0;
      s_wstrb   <= '0;
      err_irq   <= 1'b0;
      err_addr  <= '0;
      err_code  <= ERR_NONE;
      err_count <= '0;
      to_cnt    <= '0;
    end else begin
      m_ready <= 1'b0;
      err_irq <= 1'b0;

      if (launch) begin
        s_valid <= sel;
        s_addr  <= m_addr;
        s_wdata <= m_wdata;
        s_wstrb <= m_wstrb;
        to_cnt  <= '0;
      end else if (state == ST_ACCESS) begin
        to_cnt <= to_cnt + 16'd1;
      end

      if (resp_ok || resp_to) s_valid <= '0;
      if (resp_ok || resp_to || unmapped || win_acc) m_ready <= 1'b1;

      if (resp_ok)             m_rdata <= sel_rdata;
      else if (win_acc)        m_rdata <= win_rdata;
      else if (err_set)        m_rdata <= ERR_RDATA;

      if (err_set) begin
        err_irq  <= 1'b1;
        err_addr <= unmapped ? m_addr : s_addr;
        err_code <= unmapped ? ERR_UNMAPPED : ERR_TIMEOUT;
        if (err_count != 8'hFF) err_count <= err_count + 8'd1;
      end else if (win_clr) begin
        err_code  <= ERR_NONE;
        err_count <= '0;
      end
    end
  end

endmodule
`default_nettype wire
